// File: rtl/branch_predictor.sv
// Direction predictor: saturating-counter table with bimodal or gshare indexing,
// speculative global history with mispredict restore, and a post-reset table sweep.
module branch_predictor #(
    parameter int IDX_W = 12,
    parameter int CTR_W = 2,
    parameter int GHR_W = 8,
    parameter int MODE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             pred_req,
    input  logic [31:0]      pred_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic             busy
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] INIT_CTR = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_MIN  = '0;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   sweep_reg, sweep_next;
    logic [GHR_W-1:0]   ghr_reg, ghr_next;
    logic               pred_valid_reg;
    logic               pred_taken_reg;
    logic [GHR_W-1:0]   pred_ghr_reg;

    logic [CTR_W-1:0]   ctr_mem [DEPTH];

    logic [IDX_W-1:0]   lk_hist, upd_hist;
    logic [IDX_W-1:0]   lk_idx, upd_idx;
    logic [CTR_W-1:0]   upd_ctr;
    logic               accept, recover;
    logic               wr_en, mem_we;
    logic [IDX_W-1:0]   wr_idx;
    logic [CTR_W-1:0]   wr_data;

    // History is zero-extended; index bits above GHR_W come from the PC alone.
    genvar gi;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_hist
            if (MODE != 0 && gi < GHR_W) begin : g_xor
                assign lk_hist[gi]  = ghr_reg[gi];
                assign upd_hist[gi] = upd_ghr[gi];
            end else begin : g_pc_only
                assign lk_hist[gi]  = 1'b0;
                assign upd_hist[gi] = 1'b0;
            end
        end
    endgenerate

    assign lk_idx  = pred_pc[IDX_W+1:2] ^ lk_hist;
    assign upd_idx = upd_pc[IDX_W+1:2] ^ upd_hist;
    assign upd_ctr = ctr_mem[upd_idx];

    logic unused_bits;
    assign unused_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                           upd_pc[31:IDX_W+2], upd_pc[1:0], upd_ghr};

    function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] h, input logic b);
        logic [GHR_W:0] t;
        t = {h, b};
        return t[GHR_W-1:0];
    endfunction

    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        ghr_next   = ghr_reg;
        accept     = 1'b0;
        recover    = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = sweep_reg;
        wr_data    = INIT_CTR;
        if (rdy) begin
            case (state_reg)
                ST_INIT: begin
                    wr_en      = 1'b1;
                    sweep_next = sweep_reg + 1'b1;
                    if (&sweep_reg)
                        state_next = ST_RUN;
                end
                ST_RUN: begin
                    recover = upd_valid & upd_mispredict;
                    // A request arriving alongside a recovery would see stale history.
                    accept  = pred_req & ~recover;
                    if (recover)
                        ghr_next = shift_in(upd_ghr, upd_taken);
                    else if (pred_valid_reg)
                        ghr_next = shift_in(ghr_reg, pred_taken_reg);
                    if (upd_valid) begin
                        wr_en  = 1'b1;
                        wr_idx = upd_idx;
                        if (upd_taken)
                            wr_data = (upd_ctr == CTR_MAX) ? upd_ctr : upd_ctr + 1'b1;
                        else
                            wr_data = (upd_ctr == CTR_MIN) ? upd_ctr : upd_ctr - 1'b1;
                    end
                end
                default: state_next = ST_INIT;
            endcase
        end
    end

    assign mem_we = wr_en & ~rst;

    // Read-before-write: a same-cycle lookup of the written entry sees the old counter.
    always_ff @(posedge clk) begin
        if (mem_we)
            ctr_mem[wr_idx] <= wr_data;
        if (rst)
            pred_taken_reg <= 1'b0;
        else if (accept)
            pred_taken_reg <= ctr_mem[lk_idx][CTR_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_INIT;
            sweep_reg      <= '0;
            ghr_reg        <= '0;
            pred_valid_reg <= 1'b0;
            pred_ghr_reg   <= '0;
        end else if (rdy) begin
            state_reg      <= state_next;
            sweep_reg      <= sweep_next;
            ghr_reg        <= ghr_next;
            pred_valid_reg <= accept;
            if (accept)
                pred_ghr_reg <= ghr_reg;
        end
    end

    assign pred_valid = pred_valid_reg;
    assign pred_taken = pred_taken_reg;
    assign pred_ghr   = pred_ghr_reg;
    assign busy       = (state_reg == ST_INIT);

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: bimodal and gshare instances driven in lockstep,
// a behavioural model feeding per-instance scoreboards, plus hand-derived directed checks.
module tb_branch_predictor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, pred_req;
    logic [31:0] pred_pc, upd_pc;
    logic [3:0]  upd_ghr;
    logic        upd_valid, upd_taken, upd_mispredict;

    logic        pv [2];
    logic        pt [2];
    logic [3:0]  pg [2];
    logic        bz [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            branch_predictor #(
                .IDX_W(4), .CTR_W(2), .GHR_W(4), .MODE(gi)
            ) u_dut (
                .clk            (clk),
                .rst            (rst),
                .rdy            (rdy),
                .pred_req       (pred_req),
                .pred_pc        (pred_pc),
                .pred_valid     (pv[gi]),
                .pred_taken     (pt[gi]),
                .pred_ghr       (pg[gi]),
                .upd_valid      (upd_valid),
                .upd_pc         (upd_pc),
                .upd_ghr        (upd_ghr),
                .upd_taken      (upd_taken),
                .upd_mispredict (upd_mispredict),
                .busy           (bz[gi])
            );
        end
    endgenerate

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state, one copy per instance (0 = bimodal, 1 = gshare)
    logic [1:0]  mt [2][16];
    logic [3:0]  mg [2];
    logic        mpv [2];
    logic        mpt [2];
    logic        m_new [2];
    logic        m_init = 1'b1;
    logic [3:0]  m_s = 4'd0;
    logic [4:0]  sb_q0 [$];
    logic [4:0]  sb_q1 [$];

    function automatic logic [3:0] idx_of(input int m, input logic [31:0] pc, input logic [3:0] g);
        logic [3:0] r;
        r = pc[5:2];
        if (m == 1)
            r = r ^ g;
        return r;
    endfunction

    task automatic cycle();
        logic [1:0] rd;
        logic [3:0] li, ui, g_n;
        logic       acc;
        logic [4:0] e;
        for (int m = 0; m < 2; m++) m_new[m] = 1'b0;
        if (rst) begin
            m_init = 1'b1;
            m_s    = 4'd0;
            for (int m = 0; m < 2; m++) begin
                mg[m] = 4'd0; mpv[m] = 1'b0; mpt[m] = 1'b0;
            end
        end else if (rdy) begin
            if (m_init) begin
                for (int m = 0; m < 2; m++) mt[m][m_s] = 2'd1;
                if (m_s == 4'd15) m_init = 1'b0;
                m_s = m_s + 4'd1;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    acc = pred_req && !(upd_valid && upd_mispredict);
                    if (upd_valid && upd_mispredict) g_n = {upd_ghr[2:0], upd_taken};
                    else if (mpv[m])                 g_n = {mg[m][2:0], mpt[m]};
                    else                             g_n = mg[m];
                    if (acc) begin
                        li = idx_of(m, pred_pc, mg[m]);
                        rd = mt[m][li];
                        mpt[m] = rd[1];
                        if (m == 0) sb_q0.push_back({rd[1], mg[m]});
                        else        sb_q1.push_back({rd[1], mg[m]});
                    end
                    mpv[m]   = acc;
                    m_new[m] = acc;
                    mg[m]    = g_n;
                    if (upd_valid) begin
                        ui = idx_of(m, upd_pc, upd_ghr);
                        if (upd_taken) begin
                            if (mt[m][ui] != 2'd3) mt[m][ui] = mt[m][ui] + 2'd1;
                        end else begin
                            if (mt[m][ui] != 2'd0) mt[m][ui] = mt[m][ui] - 2'd1;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check_val($sformatf("busy_%0d", m), bz[m], m_init);
            check_val($sformatf("pred_valid_%0d", m), pv[m], mpv[m]);
            if (m_new[m]) begin
                if (m == 0) e = (sb_q0.size() > 0) ? sb_q0.pop_front() : 5'bx;
                else        e = (sb_q1.size() > 0) ? sb_q1.pop_front() : 5'bx;
                check_val($sformatf("pred_taken_%0d", m), pt[m], e[4]);
                check_val($sformatf("pred_ghr_%0d", m), pg[m], e[3:0]);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic lookup(input logic [31:0] pc);
        pred_req = 1'b1;
        pred_pc  = pc;
        cycle();
        pred_req = 1'b0;
        $display("[TB] lookup pc=%08h bim v=%b t=%b g=%h | gsh v=%b t=%b g=%h",
                 pc, pv[0], pt[0], pg[0], pv[1], pt[1], pg[1]);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [3:0] g, input logic tk, input logic mp);
        upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = tk; upd_mispredict = mp;
        cycle();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
        $display("[TB] update pc=%08h ghr=%h taken=%b mispredict=%b", pc, g, tk, mp);
    endtask

    task automatic wait_sweep(output int cnt);
        cnt = 0;
        while (bz[0] === 1'b1 && cnt < 200) begin
            cnt++;
            cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int cnt;

    initial begin
        rst = 1'b1; rdy = 1'b1; pred_req = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
        idle(2);
        rst = 1'b0;

        // Sweep with requests held high: none may be accepted
        pred_req = 1'b1; pred_pc = 32'h40;
        wait_sweep(cnt);
        pred_req = 1'b0;
        check_val("sweep_len", cnt, 16);
        check_val("busy_req_dropped", pv[0], 0);
        for (int a = 0; a < 16; a++) begin
            lookup(32'(a * 4));
            check_val("init_bim", pt[0], 0);
            check_val("init_gsh", pt[1], 0);
        end

        // Saturation on entry 0 (bimodal counter starts at 1)
        repeat (5) upd(32'h40, 4'h0, 1'b1, 1'b0);
        lookup(32'h40); check_val("sat_hi", pt[0], 1);
        upd(32'h40, 4'h0, 1'b0, 1'b0);
        lookup(32'h40); check_val("sat_dec1", pt[0], 1);
        upd(32'h40, 4'h0, 1'b0, 1'b0);
        lookup(32'h40); check_val("sat_dec2", pt[0], 0);
        repeat (3) upd(32'h40, 4'h0, 1'b0, 1'b0);
        upd(32'h40, 4'h0, 1'b1, 1'b0);
        lookup(32'h40); check_val("sat_lo1", pt[0], 0);
        upd(32'h40, 4'h0, 1'b1, 1'b0);
        lookup(32'h40); check_val("sat_lo2", pt[0], 1);
        upd(32'h40, 4'h0, 1'b0, 1'b0);

        // gshare: build history 0101 from predictions N,T,N,T
        repeat (2) upd(32'h1C, 4'h0, 1'b1, 1'b0);
        idle(2);
        upd(32'h3C, 4'h0, 1'b0, 1'b1);
        lookup(32'h04); check_val("gs_p0", pt[1], 0); idle(1);
        lookup(32'h1C); check_val("gs_p1", pt[1], 1); idle(1);
        lookup(32'h08); check_val("gs_p2", pt[1], 0); idle(1);
        lookup(32'h14); check_val("gs_p3", pt[1], 1); idle(1);
        lookup(32'h14);
        check_val("gs_ghr", pg[1], 4'b0101);
        check_val("gs_alias", pt[1], 0);
        upd(32'h14, 4'b0101, 1'b1, 1'b0);
        upd(32'h3C, 4'b0010, 1'b1, 1'b1);
        lookup(32'h14);
        check_val("gs_ghr2", pg[1], 4'b0101);
        check_val("gs_upd", pt[1], 1);

        // Same-index update and lookup in one cycle
        pred_req = 1'b1; pred_pc = 32'h24;
        upd_valid = 1'b1; upd_pc = 32'h24; upd_ghr = 4'h0; upd_taken = 1'b1;
        cycle();
        pred_req = 1'b0; upd_valid = 1'b0;
        check_val("coll_old", pt[0], 0);
        lookup(32'h24); check_val("coll_new", pt[0], 1);

        // rdy low in RUN: inputs ignored, state frozen
        rdy = 1'b0; pred_req = 1'b1; pred_pc = 32'h24;
        upd_valid = 1'b1; upd_pc = 32'h24; upd_ghr = 4'h0; upd_taken = 1'b0;
        idle(3);
        rdy = 1'b1; pred_req = 1'b0; upd_valid = 1'b0;
        lookup(32'h24); check_val("rdy_hold", pt[0], 1);

        // Recovery coinciding with a new request
        idle(2);
        lookup(32'h24); lookup(32'h28); lookup(32'h2C);
        pred_req = 1'b1; pred_pc = 32'h30;
        upd_valid = 1'b1; upd_pc = 32'h3C; upd_ghr = 4'b0011; upd_taken = 1'b1; upd_mispredict = 1'b1;
        cycle();
        pred_req = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        check_val("rec_drop_bim", pv[0], 0);
        check_val("rec_drop_gsh", pv[1], 0);
        lookup(32'h30);
        check_val("rec_ghr_bim", pg[0], 4'b0111);
        check_val("rec_ghr_gsh", pg[1], 4'b0111);

        // Sweep stretched by a 5-cycle rdy stall
        rst = 1'b1; cycle(); rst = 1'b0;
        cnt = 0;
        while (bz[0] === 1'b1 && cnt < 200) begin
            cnt++;
            rdy = (cnt < 5 || cnt >= 10);
            cycle();
        end
        rdy = 1'b1;
        check_val("stall_sweep_len", cnt, 21);

        // Reset at sweep entry 9 restarts a full sweep
        rst = 1'b1; cycle(); rst = 1'b0;
        idle(9);
        rst = 1'b1; cycle(); rst = 1'b0;
        wait_sweep(cnt);
        check_val("restart_sweep_len", cnt, 16);
        lookup(32'h24); check_val("reinit", pt[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
